bram_weight_loader: RTL and testbench

//  Upstream write stage for bram_dual port A (weight buffer feeding the NDP unit).

---
 rtl/bram_weight_loader.sv | 118 +++++++++++
 tb/tb_bram_weight_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bram_weight_loader.sv
// Streams weight words into bram_dual port A, zero-pads the last partial line of a tile,
// flags each finished line and the sealed buffer to the port-B reader, and waits for release.
//   state | meaning
//   FILL  | accepting stream words
//   PAD   | writing zeros to finish the current line
//   FULL  | buffer sealed, waiting for buf_release
module bram_weight_loader #(
    parameter int A_WIDTH         = 32,
    parameter int COUNT           = 2,
    parameter int A_ADDRESS_WIDTH = 1,
    parameter int B_ADDRESS_WIDTH = 0,
    localparam int LA_W           = (B_ADDRESS_WIDTH > 0) ? B_ADDRESS_WIDTH : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [A_WIDTH-1:0]         s_data,
    input  logic                       s_last,
    output logic                       bram_ena,
    output logic                       bram_wea,
    output logic [A_ADDRESS_WIDTH-1:0] bram_addra,
    output logic [A_WIDTH-1:0]         bram_dina,
    output logic                       line_done,
    output logic [LA_W-1:0]            line_addr,
    output logic                       buf_full,
    output logic [A_ADDRESS_WIDTH:0]   word_count,
    input  logic                       buf_release
);

    localparam int LW    = (COUNT > 1) ? $clog2(COUNT) : 0;
    localparam int DEPTH = 2 ** A_ADDRESS_WIDTH;
    localparam logic [A_ADDRESS_WIDTH-1:0] LINE_MASK = A_ADDRESS_WIDTH'(COUNT - 1);
    localparam logic [A_ADDRESS_WIDTH:0]   WC_MAX    = (A_ADDRESS_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {FILL, PAD, FULL} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [A_ADDRESS_WIDTH-1:0] wr_ptr;
    logic                       accept;
    logic                       do_write;
    logic                       line_end;
    logic                       buf_end;
    logic [A_WIDTH-1:0]         wr_data;

    // With COUNT=1 the mask is zero, so every write ends a line.
    assign line_end = (wr_ptr & LINE_MASK) == LINE_MASK;
    assign buf_end  = &wr_ptr;
    assign accept   = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (buf_end || (s_last && line_end)) state_next = FULL;
                    else if (s_last)                     state_next = PAD;
                end
            end
            PAD:     if (line_end) state_next = FULL;
            FULL:    if (buf_release) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        s_ready  = 1'b0;
        do_write = 1'b0;
        wr_data  = '0;
        case (state)
            FILL: begin
                s_ready  = 1'b1;
                do_write = s_valid;
                wr_data  = s_data;
            end
            PAD:     do_write = 1'b1;
            default: ;
        endcase
    end

    // buf_full trails the FULL state by one cycle so the last write has landed first.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            word_count <= '0;
            bram_ena   <= 1'b0;
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            line_done  <= 1'b0;
            line_addr  <= '0;
            buf_full   <= 1'b0;
        end else begin
            bram_ena  <= do_write;
            bram_wea  <= do_write;
            line_done <= do_write && line_end;
            buf_full  <= (state == FULL) && !buf_release;
            if (do_write) begin
                bram_addra <= wr_ptr;
                bram_dina  <= wr_data;
                if (!buf_end) wr_ptr <= wr_ptr + A_ADDRESS_WIDTH'(1);
            end
            if (do_write && line_end) line_addr <= LA_W'(wr_ptr >> LW);
            if (accept && word_count != WC_MAX) word_count <= word_count + (A_ADDRESS_WIDTH + 1)'(1);
            if (state == FULL && buf_release) begin
                wr_ptr     <= '0;
                word_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bram_weight_loader.sv
// Directed and random stimulus for bram_weight_loader, checked cycle by cycle against a
// tile-level model (words-written count, pad remainder, sealed flag).
module tb_bram_weight_loader;

    localparam int AW    = 32;
    localparam int CNT   = 2;
    localparam int AAW   = 3;
    localparam int BAW   = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [AW-1:0]  s_data = '0;
    logic           s_last = 1'b0;
    logic           bram_ena;
    logic           bram_wea;
    logic [AAW-1:0] bram_addra;
    logic [AW-1:0]  bram_dina;
    logic           line_done;
    logic [BAW-1:0] line_addr;
    logic           buf_full;
    logic [AAW:0]   word_count;
    logic           buf_release = 1'b0;

    bram_weight_loader #(
        .A_WIDTH(AW), .COUNT(CNT), .A_ADDRESS_WIDTH(AAW), .B_ADDRESS_WIDTH(BAW)
    ) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .line_done(line_done), .line_addr(line_addr), .buf_full(buf_full),
        .word_count(word_count), .buf_release(buf_release)
    );

    always #5 clk = ~clk;

    // Port-A side of the weight buffer; port B is read as a COUNT-word concatenation.
    logic [AW-1:0] mem [DEPTH];
    always @(posedge clk) if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;

    int n_cmp = 0;
    int n_bad = 0;

    bit             init = 0;
    bit             sealed = 0;
    int             ptr = 0;
    int             words = 0;
    int             pad_left = 0;
    logic           exp_ena = 0;
    logic           exp_ld = 0;
    logic [AAW-1:0] exp_addr = '0;
    logic [AW-1:0]  exp_data = '0;
    logic [BAW-1:0] exp_la = '0;
    logic           exp_full = 0;
    logic [AAW:0]   exp_wc = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic model_ready();
        return init && !sealed && pad_left == 0;
    endfunction

    task automatic model_write(input logic [AW-1:0] d);
        exp_ena  = 1'b1;
        exp_addr = ptr[AAW-1:0];
        exp_data = d;
        if (ptr % CNT == CNT - 1) begin
            exp_ld = 1'b1;
            exp_la = BAW'(ptr / CNT);
        end
        ptr++;
    endtask

    task automatic model_update(input bit v, input logic [AW-1:0] d, input bit l, input bit rel, input bit rst);
        bit was;
        if (rst) begin
            init = 1; sealed = 0; ptr = 0; words = 0; pad_left = 0;
            exp_ena = 0; exp_ld = 0; exp_addr = '0; exp_data = '0;
            exp_la = '0; exp_full = 0; exp_wc = '0;
            return;
        end
        if (!init) return;
        was = sealed;
        exp_ena = 0;
        exp_ld = 0;
        if (pad_left > 0) begin
            model_write('0);
            pad_left--;
            if (pad_left == 0) sealed = 1;
        end else if (sealed) begin
            if (rel) begin
                sealed = 0; ptr = 0; words = 0;
            end
        end else if (v) begin
            model_write(d);
            if (words < DEPTH) words++;
            if (ptr == DEPTH || (l && ptr % CNT == 0)) sealed = 1;
            else if (l) pad_left = CNT - ptr % CNT;
        end
        exp_full = was && sealed;
        exp_wc   = (AAW + 1)'(words);
    endtask

    task automatic check_outputs();
        chk("s_ready",    64'(s_ready),    64'(model_ready()));
        chk("bram_ena",   64'(bram_ena),   64'(exp_ena));
        chk("bram_wea",   64'(bram_wea),   64'(exp_ena));
        chk("bram_addra", 64'(bram_addra), 64'(exp_addr));
        chk("bram_dina",  64'(bram_dina),  64'(exp_data));
        chk("line_done",  64'(line_done),  64'(exp_ld));
        chk("line_addr",  64'(line_addr),  64'(exp_la));
        chk("buf_full",   64'(buf_full),   64'(exp_full));
        chk("word_count", 64'(word_count), 64'(exp_wc));
    endtask

    task automatic step(input bit v, input logic [AW-1:0] d, input bit l, input bit rel, input bit rst);
        reset = rst; s_valid = v; s_data = d; s_last = l; buf_release = rel;
        @(negedge clk);
        if (init) check_outputs();
        model_update(v, d, l, rel, rst);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] line_b;

        // reset, then idle with s_ready expected high
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 0);

        // full buffer back to back
        for (int i = 0; i < 8; i++) step(1, AW'((i + 1) * 32'h11), i == 7, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        line_b = {mem[1], mem[0]};
        chk("portb_line0", line_b, 64'h00000022_00000011);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 0, 0);

        // gapped valid; release during FILL must be ignored
        for (int i = 0; i < 8; i++) step(i % 2 == 0, AW'(32'h100 + i), i == 6, i == 2, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);

        // short tile ending mid-line gets a pad word
        step(1, 32'hAA, 0, 0, 0);
        step(1, 32'hBB, 0, 0, 0);
        step(1, 32'hCC, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'hDD, 0, 0, 0);
        line_b = {mem[3], mem[2]};
        chk("portb_line1_pad", line_b, 64'h00000000_000000CC);
        step(0, '0, 0, 1, 0);
        step(1, 32'hEE, 0, 0, 0);

        // reset in the middle of a fill
        for (int i = 0; i < 4; i++) step(1, AW'(32'h200 + i), 0, 0, 0);
        step(1, 32'h2FF, 0, 0, 1);
        step(1, 32'h300, 0, 0, 0);
        step(0, '0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
